alu_control: RTL and testbench



---
 rtl/alu_control.sv | 65 ++++++
 tb/tb_alu_control.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_control.sv
// alu_control: registered opcode/function-code decode to the 3-bit ALU operation select.
// Optional registered decodeErr output enabled by ALU_CONTROL_DECODE_ERR_EN.
module alu_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opCode,
    input  logic [3:0] funCode,
`ifdef ALU_CONTROL_DECODE_ERR_EN
    output logic       decodeErr,
`endif
    output logic [2:0] aluOp
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    logic [2:0] alu_op_d, alu_op_q;

    // case compares with ===, so X/Z inputs fall through to the default rows
    always_comb begin
        alu_op_d = OP_ADD;
        case (opCode)
            4'b0000: case (funCode)
                4'b0001: alu_op_d = OP_SUB;
                4'b0100: alu_op_d = OP_AND;
                4'b0101: alu_op_d = OP_OR;
                default: alu_op_d = OP_ADD;
            endcase
            4'b0001: alu_op_d = OP_AND;
            4'b0010: alu_op_d = OP_OR;
            default: alu_op_d = OP_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) alu_op_q <= OP_ADD;
        else     alu_op_q <= alu_op_d;
    end

    assign aluOp = alu_op_q;

`ifdef ALU_CONTROL_DECODE_ERR_EN
    logic decode_err_d, decode_err_q;

    always_comb begin
        decode_err_d = 1'b1;
        case (opCode)
            4'b0000: case (funCode)
                4'b0000, 4'b0001, 4'b0100, 4'b0101: decode_err_d = 1'b0;
                default: decode_err_d = 1'b1;
            endcase
            4'b0001, 4'b0010, 4'b1010, 4'b1011, 4'b1100, 4'b1101: decode_err_d = 1'b0;
            default: decode_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) decode_err_q <= 1'b0;
        else     decode_err_q <= decode_err_d;
    end

    assign decodeErr = decode_err_q;
`endif
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed checks of alu_control decode, latency and reset behaviour.
module tb_alu_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opCode = 4'b0000;
    logic [3:0] funCode = 4'b0000;
    logic [2:0] aluOp;
`ifdef ALU_CONTROL_DECODE_ERR_EN
    logic       decodeErr;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    alu_control dut (
        .clk(clk),
        .rst(rst),
        .opCode(opCode),
        .funCode(funCode),
`ifdef ALU_CONTROL_DECODE_ERR_EN
        .decodeErr(decodeErr),
`endif
        .aluOp(aluOp)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then check the registered result 1 time unit later.
    task automatic step(input string tag, input logic r, input logic [3:0] op, input logic [3:0] fn,
                        input logic [2:0] exp_op, input logic exp_err);
        rst = r;
        opCode = op;
        funCode = fn;
        @(posedge clk);
        #1;
        n_cmp++;
        assert (aluOp === exp_op)
        else begin
            n_bad++;
            $error("FAIL %s aluOp observed=%b expected=%b", tag, aluOp, exp_op);
        end
`ifdef ALU_CONTROL_DECODE_ERR_EN
        n_cmp++;
        assert (decodeErr === exp_err)
        else begin
            n_bad++;
            $error("FAIL %s decodeErr observed=%b expected=%b", tag, decodeErr, exp_err);
        end
`else
        if (exp_err === 1'bz) $display("unreachable");
`endif
    endtask

    // Expected decode for an all-X opcode: a 2-state simulator may resolve the X to a
    // concrete value, in which case the known-opcode table applies.
    function automatic logic [3:0] expect_for(input logic [3:0] op, input logic [3:0] fn);
        if ($isunknown(op)) return 4'b1000;
        if (op === 4'b0000) begin
            if (fn === 4'b0000) return 4'b0000;
            if (fn === 4'b0001) return 4'b0001;
            if (fn === 4'b0100) return 4'b0100;
            if (fn === 4'b0101) return 4'b0101;
            return 4'b1000;
        end
        if (op === 4'b0001) return 4'b0100;
        if (op === 4'b0010) return 4'b0101;
        if (op >= 4'b1010 && op <= 4'b1101) return 4'b0000;
        return 4'b1000;
    endfunction

    logic [3:0] ex;

    initial begin
        step("reset_edge1",   1'b1, 4'b0001, 4'b0000, 3'b000, 1'b0);
        step("reset_edge2",   1'b1, 4'b0001, 4'b0000, 3'b000, 1'b0);
        step("reset_release", 1'b0, 4'b0001, 4'b0000, 3'b100, 1'b0);

        step("r_add", 1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0);
        step("r_sub", 1'b0, 4'b0000, 4'b0001, 3'b001, 1'b0);
        step("r_and", 1'b0, 4'b0000, 4'b0100, 3'b100, 1'b0);
        step("r_or",  1'b0, 4'b0000, 4'b0101, 3'b101, 1'b0);

        step("andi_funx", 1'b0, 4'b0001, 4'bxxxx, 3'b100, 1'b0);
        step("ori_fun7",  1'b0, 4'b0010, 4'b0111, 3'b101, 1'b0);
        step("ori_funf",  1'b0, 4'b0010, 4'b1111, 3'b101, 1'b0);

        step("ld_1010", 1'b0, 4'b1010, 4'b0101, 3'b000, 1'b0);
        step("ld_1011", 1'b0, 4'b1011, 4'b0001, 3'b000, 1'b0);
        step("st_1100", 1'b0, 4'b1100, 4'b0100, 3'b000, 1'b0);
        step("st_1101", 1'b0, 4'b1101, 4'b0101, 3'b000, 1'b0);

        step("bad_fun",    1'b0, 4'b0000, 4'b0010, 3'b000, 1'b1);
        step("after_or",   1'b0, 4'b0010, 4'b0000, 3'b101, 1'b0);
        step("bad_op0111", 1'b0, 4'b0111, 4'b0010, 3'b000, 1'b1);
        step("after_and",  1'b0, 4'b0001, 4'b0000, 3'b100, 1'b0);
        opCode = 4'bxxxx;
        funCode = 4'b0010;
        ex = expect_for(opCode, funCode);
        step("bad_opx", 1'b0, opCode, funCode, ex[2:0], ex[3]);
        step("r_fun_x_hi", 1'b0, 4'b0000, 4'b1000, 3'b000, 1'b1);

        step("sub_before_rst", 1'b0, 4'b0000, 4'b0001, 3'b001, 1'b0);
        step("rst_mid_sub",    1'b1, 4'b0000, 4'b0001, 3'b000, 1'b0);
        step("post_rst_or",    1'b0, 4'b0010, 4'b0000, 3'b101, 1'b0);
        step("post_rst_sub",   1'b0, 4'b0000, 4'b0001, 3'b001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
